// File: rtl/cnt01_pkg.sv
// Shared types for the bit-majority classifier path: deserializer FSM
// state encodings, word width, and the classifier's verdict codes.
package cnt01_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    LESS1 = 2'b00,
    MORE1 = 2'b01,
    EQUAL = 2'b10
  } verdict_t;

  // Majority verdict of a classifier input word.
  function automatic verdict_t classify(input logic [BYTE_W-1:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < BYTE_W; i++) ones += int'(b[i]);
    if (ones > BYTE_W / 2) return MORE1;
    if (ones < BYTE_W / 2) return LESS1;
    return EQUAL;
  endfunction

endpackage

// File: rtl/byte_deserializer.sv
// Serial-to-parallel front end: assembles WIDTH accepted bits into a word
// and offers it downstream over a valid/ready handshake.
// Ports: clk, reset (async, active-high); bit_in/bit_valid/bit_ready bit
// stream in; flush drops a partial word; byte_out/byte_valid/byte_ready
// word out; frame_err pulses when a flush discarded accepted bits.
import cnt01_pkg::*;

module byte_deserializer #(
  parameter int WIDTH     = BYTE_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nx;
  logic [CW-1:0]    count, count_nx;
  logic [WIDTH-1:0] sr, sr_nx;
  logic [WIDTH-1:0] out_nx;
  logic             ferr_nx;
  logic [WIDTH-1:0] shifted;
  logic             accept;

  always_comb begin
    if (MSB_FIRST) shifted = {sr[WIDTH-2:0], bit_in};
    else           shifted = {bit_in, sr[WIDTH-1:1]};
  end

  // In FULL the consumer's ready passes straight through, so a word
  // leaving and the next word's first bit share one cycle.
  always_comb begin
    bit_ready = 1'b0;
    case (state)
      ST_IDLE: bit_ready = 1'b1;
      ST_FILL: bit_ready = ~flush;
      ST_FULL: bit_ready = byte_ready;
      default: bit_ready = 1'b0;
    endcase
    if (reset) bit_ready = 1'b0;
  end

  assign accept     = bit_valid & bit_ready;
  assign byte_valid = (state == ST_FULL);

  always_comb begin
    state_nx = state;
    count_nx = count;
    sr_nx    = sr;
    out_nx   = byte_out;
    ferr_nx  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          sr_nx    = shifted;
          count_nx = CW'(1);
          state_nx = ST_FILL;
        end
      end
      ST_FILL: begin
        if (flush) begin
          state_nx = ST_IDLE;
          count_nx = '0;
          sr_nx    = '0;
          ferr_nx  = 1'b1;
        end else if (accept) begin
          sr_nx = shifted;
          if (count == CW'(WIDTH - 1)) begin
            state_nx = ST_FULL;
            count_nx = CW'(WIDTH);
            out_nx   = shifted;
          end else begin
            count_nx = count + CW'(1);
          end
        end
      end
      ST_FULL: begin
        if (byte_ready) begin
          // A pass-through bit taken during flush is dropped silently.
          if (accept && !flush) begin
            sr_nx    = shifted;
            count_nx = CW'(1);
            state_nx = ST_FILL;
          end else begin
            sr_nx    = '0;
            count_nx = '0;
            state_nx = ST_IDLE;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        count_nx = '0;
        sr_nx    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      sr        <= '0;
      byte_out  <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      sr        <= sr_nx;
      byte_out  <= out_nx;
      frame_err <= ferr_nx;
    end
  end

endmodule
